// File: rtl/wb_defs_pkg.sv
// Shared Wishbone arbiter definitions: grant codes, FSM state encodings, grant helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// The state encodings match the one-hot grant codes, so a later N-master arbiter
// can reuse the same scheme.
package wb_defs_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    function automatic logic [1:0] state_to_gnt(input state_t s);
        logic [1:0] g;
        g = GNT_NONE;
        case (s)
            ST_GNT0: g = GNT_M0;
            ST_GNT1: g = GNT_M1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-ack watchdog: counts stalled strobe cycles and emits a one-cycle timeout pulse.
// Latency: pulse is combinational from the counter; it fires when the count reaches timeout.
// Backpressure: none; the counter runs only while the slave leaves a strobe unanswered.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   stb            muxed slave strobe (before the timeout forcing)
//   ack, err       slave response; either one clears the count
//   gnt_chg        grant is about to change; clears the count
//   timeout_pulse  high for exactly one cycle when the limit is reached
module wb_arb_watchdog #(
    parameter int timeout = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic gnt_chg,
    output logic timeout_pulse
);

    logic [15:0] cnt;

    assign timeout_pulse = (cnt == 16'(timeout));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (gnt_chg || ack || err || timeout_pulse) begin
            cnt <= '0;
        end else if (stb) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter, round-robin, grant held for a whole cyc burst.
// Latency: grant is registered (slave sees a request one cycle after cyc rises); data/ack paths are combinational.
// Backpressure: the losing master simply waits with cyc high; the granted master is stalled by the slave's ack.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a slave-ack watchdog that returns err after `timeout` stalled cycles.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   m0_*/m1_*                       master Wishbone ports (adr/dat/sel/we/cyc/stb in, dat/ack/err out)
//   s_*                             slave Wishbone port (muxed request out, dat/ack/err in)
//   gnt_o                           one-hot current grant (00 = idle)
module wb_arbiter2
    import wb_defs_pkg::*;
#(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int timeout   = 255
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [adr_width-1:0]   m0_adr_i,
    input  logic [dat_width-1:0]   m0_dat_i,
    output logic [dat_width-1:0]   m0_dat_o,
    input  logic [dat_width/8-1:0] m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic [adr_width-1:0]   m1_adr_i,
    input  logic [dat_width-1:0]   m1_dat_i,
    output logic [dat_width-1:0]   m1_dat_o,
    input  logic [dat_width/8-1:0] m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic [adr_width-1:0]   s_adr_o,
    output logic [dat_width-1:0]   s_dat_o,
    output logic [dat_width/8-1:0] s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic [dat_width-1:0]   s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic [1:0]             gnt_o
);

    state_t state, state_nxt;
    logic   last, last_nxt;     // last granted master; 1 after reset so m0 wins the first tie
    logic   s_stb_raw;
    logic   to_pulse;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: hold grant while cyc stays high; on release hand over directly
    // to a waiting master so back-to-back bursts have no idle bubble.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                last_nxt  = 1'b1;
            end
        endcase
    end

    // Request mux and response routing; everything is zero while idle.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_raw = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        case (state)
            ST_GNT0: begin
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_raw = m0_stb_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i | to_pulse;
            end
            ST_GNT1: begin
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_raw = m1_stb_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i | to_pulse;
            end
            default: ;
        endcase
    end

    // The timeout cycle withdraws the strobe so the slave never sees a beat
    // that the master has already been told failed.
    assign s_stb_o  = s_stb_raw & ~to_pulse;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = state_to_gnt(state);

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .timeout (timeout)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .stb           (s_stb_raw),
        .ack           (s_ack_i),
        .err           (s_err_i),
        .gnt_chg       (state_nxt != state),
        .timeout_pulse (to_pulse)
    );
`else
    // No watchdog: err is a pure pass-through. This is constant 0 for any legal limit.
    assign to_pulse = (timeout == 0);
`endif

endmodule
